// File: rtl/add_arb_pkg.sv
// Shared types for the add_arb controller: FSM states, per-op tag and default sizing.
// N and the tag index width are fixed here; the top's N parameter must match ARB_N.
package add_arb_pkg;
   localparam int ARB_N   = 4;
   localparam int ARB_W   = 8;
   localparam int ARB_LAT = 2;
   localparam int IDX_W   = $clog2(ARB_N);

   typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tag_t;

   function automatic logic [ARB_N-1:0] onehot(input logic [IDX_W-1:0] i);
      return ARB_N'(1) << i;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant with a rotating priority pointer; i_lock_hold keeps the pointer on the winner.
module rr_arbiter
   import add_arb_pkg::*;
#(
   parameter int N = ARB_N
)(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [N-1:0]     i_req,
   input  logic [N-1:0]     i_lock_hold,
   output logic [N-1:0]     o_gnt,
   output logic [IDX_W-1:0] o_idx
);
   logic [IDX_W-1:0] r_ptr;
   logic             w_found;

   // First requester at or after r_ptr, scanning upward modulo N
   always_comb begin
      w_found = 1'b0;
      o_idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && i_req[(int'(r_ptr) + k) % N]) begin
            w_found = 1'b1;
            o_idx   = IDX_W'((int'(r_ptr) + k) % N);
         end
      end
      o_gnt = (i_en && w_found) ? onehot(o_idx) : '0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_ptr <= '0;
      else if (i_en && w_found)
         r_ptr <= i_lock_hold[o_idx] ? o_idx :
                  (o_idx == IDX_W'(N - 1)) ? '0 : o_idx + 1'b1;
   end
endmodule

// File: rtl/add_arb.sv
// Shares one pipelined a+b+1 adder among N requesters, returning results by tag.
// Optional ADD_ARB_LOCK_EN adds i_lock so a locked winner keeps the round-robin pointer.
module add_arb
   import add_arb_pkg::*;
#(
   parameter int N   = ARB_N,
   parameter int W   = ARB_W,
   parameter int LAT = ARB_LAT
)(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [N-1:0]   i_req,
   input  logic [N*W-1:0] i_req_a,
   input  logic [N*W-1:0] i_req_b,
`ifdef ADD_ARB_LOCK_EN
   input  logic [N-1:0]   i_lock,
`endif
   output logic [N-1:0]   o_gnt,
   input  logic           i_pause,
   output logic           o_idle,
   output logic           o_add_start,
   output logic [W-1:0]   o_add_a,
   output logic [W-1:0]   o_add_b,
   input  logic [W-1:0]   i_add_y,
   input  logic           i_add_valid,
   output logic [N-1:0]   o_rsp_valid,
   output logic [W-1:0]   o_rsp_y,
   output logic           o_err
);
   state_t           r_state, w_next;
   tag_t [LAT:0]     r_tag;
   logic             w_run, w_xfer, w_busy, w_ret;
   logic [N-1:0]     w_lock_hold;
   logic [IDX_W-1:0] w_idx;
   logic [W-1:0]     w_a, w_b;

`ifdef ADD_ARB_LOCK_EN
   assign w_lock_hold = i_lock;
`else
   assign w_lock_hold = '0;
`endif

   rr_arbiter #(.N(N)) u_arb (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (w_run),
      .i_req       (i_req),
      .i_lock_hold (w_lock_hold),
      .o_gnt       (o_gnt),
      .o_idx       (w_idx)
   );

   assign w_xfer = |(i_req & o_gnt);

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < N; k++) begin
         if (w_idx == IDX_W'(k)) begin
            w_a = i_req_a[k*W +: W];
            w_b = i_req_b[k*W +: W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_add_start <= 1'b0;
         o_add_a     <= '0;
         o_add_b     <= '0;
      end else begin
         o_add_start <= w_xfer;
         if (w_xfer) begin
            o_add_a <= w_a;
            o_add_b <= w_b;
         end
      end
   end

   // Stage LAT lines up with i_add_valid for the op issued LAT+1 cycles earlier
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tag <= '0;
      end else begin
         r_tag[0] <= '{valid: w_xfer, idx: w_idx};
         for (int s = 1; s <= LAT; s++)
            r_tag[s] <= r_tag[s-1];
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int s = 0; s <= LAT; s++)
         w_busy = w_busy | r_tag[s].valid;
   end

   assign w_ret = r_tag[LAT].valid & i_add_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rsp_valid <= '0;
         o_rsp_y     <= '0;
         o_err       <= 1'b0;
      end else begin
         o_rsp_valid <= w_ret ? onehot(r_tag[LAT].idx) : '0;
         if (w_ret)
            o_rsp_y <= i_add_y;
         if (i_add_valid != r_tag[LAT].valid)
            o_err <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= RUN;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RUN:     if (i_pause) w_next = DRAIN;
         DRAIN:   if (!w_busy) w_next = PAUSED;
         PAUSED:  if (!i_pause) w_next = RUN;
         default: w_next = RUN;
      endcase
   end

   always_comb begin
      w_run  = (r_state == RUN);
      o_idle = (r_state == PAUSED);
   end
endmodule

// File: doc/add_arb.md
# add_arb

Round-robin controller that shares one pipelined add-plus-one datapath (`y = a + b + 1`, 2-cycle start-to-valid latency) among N requesters. It arbitrates requests, drives the datapath's start/operand inputs, and tracks each issued operation by requester tag. It returns each result to the requester that issued it, and supports a pause/drain sequence for quiescing the datapath. It sits directly in front of the adder instance; requesters never touch the adder directly.

## Interface
- `N`, 4, number of requesters (≥2)
- `W`, 8, operand/result width; must equal the adder's W
- `LAT`, 2, adder latency, from `add_start` to `add_valid`
- `clk` in 1, single clock
- `rst` in 1, reset; synchronous, active-high
- `req` in N, per-requester request; held with operands until granted
- `req_a` in N*W, operand a, requester i at bits [i*W +: W]
- `req_b` in N*W, operand b, same packing
- `gnt` out N, one-hot combinational grant; transfer occurs when `req[i] && gnt[i]`
- `pause` in 1, stop issuing and drain the datapath
- `idle` out 1, high in PAUSED state
- `add_start`, `add_a`, `add_b` out 1/W/W, registered drive into the adder
- `add_y`, `add_valid` in W/1, adder result
- `rsp_valid` out N, one-hot registered result strobe
- `rsp_y` out W, registered result, valid with `rsp_valid`
- `err` out 1, sticky tag/valid mismatch flag

## Operation
- **FSM states:** RUN, DRAIN, PAUSED.
  - RUN → DRAIN when `pause` is 1.
  - DRAIN → PAUSED when the tag pipeline is empty.
  - PAUSED → RUN when `pause` is 0.
  - DRAIN ignores `pause` deassertion and always passes through PAUSED.
- **Grant:** `gnt` is nonzero only in RUN. The winner is the first `req` bit at or after `ptr`, scanning upward mod N. On a transfer to i, `ptr` ← (i+1) mod N.
- **Issue:** on a transfer from requester i, register `add_start`=1, `add_a`=`req_a[i]`, `add_b`=`req_b[i]`. `add_start`=0 otherwise.
  - One issue per cycle is allowed; back-to-back issues are legal because the adder is fully pipelined.
- **Tag pipeline:** LAT+1 stages of {valid, idx}, shifted every cycle. Stage 0 is loaded on a transfer. `add_valid` must coincide with the last stage being valid.
- **Return:** when the last stage is valid and `add_valid`=1, next cycle `rsp_valid[idx]`=1 and `rsp_y`=`add_y`. `rsp_y` holds its value otherwise.
- **Error:** `err` sets if `add_valid` differs from the last-stage valid bit. It clears only on `rst`. The response is still steered by the tag.
- **Arithmetic:** results wrap mod 2^W; the carry is discarded by the adder.
- **Reset values:** `ptr`=0, state=RUN, all tag stages invalid, `add_start`/`add_a`/`add_b`=0, `rsp_valid`=0, `rsp_y`=0, `err`=0, `idle`=0.
- **Reset mid-operation:** in-flight tags are discarded and no `rsp_valid` is produced for them. The adder is reset by the same system reset event.

## Timing
- Transfer at cycle t; `add_start` at t+1; `add_valid` at t+1+LAT; `rsp_valid` at t+2+LAT (t+4 at default).
- `gnt` depends combinationally on `req`, `ptr` and state only, never on `req_a`/`req_b`.
- `pause` sampled high at t: no grant from t+1 onward. A grant is still possible in cycle t itself, because `gnt` is combinational on state (RUN).
- DRAIN lasts until the last in-flight response has been returned: `idle` rises the cycle after the tag pipeline empties, at most LAT+2 cycles after entering DRAIN.

## Configuration
- `ADD_ARB_LOCK_EN` defined:
  - Adds input `lock` (N bits).
  - If the granted requester i has `lock[i]`=1, `ptr` stays at i, so i keeps winning while `req[i]` is held.
  - Locking does not bypass `pause`.
- Not defined: no `lock` port; pure round-robin.

## Structure
- Package `add_arb_pkg` holds:
  - the state enum (RUN/DRAIN/PAUSED);
  - the tag struct {valid, idx};
  - the idx width, computed as $clog2(N).
- Sub-module `rr_arbiter` holds the combinational grant and `ptr` register, with a lock-hold input tied 0 when the macro is off.
- The tag pipeline, FSM and response register live in the top module.

## Test plan
- Single request, N=4, W=8: req[0], a=3, b=4 at t → `add_start` at t+1, `rsp_valid`=0001 with `rsp_y`=8 at t+4.
- All four requesters held for 8 cycles → grant order 0,1,2,3,0,1,2,3; each `rsp_y`=a+b+1; `rsp_valid` order matches.
- Wrap-around: a=0xFF, b=0x00 → `rsp_y`=0x00; a=0x80, b=0x7F → `rsp_y`=0x00.
- Pause with 3 ops in flight → no further `gnt`; all 3 responses delivered; `idle`=1; deasserting `pause` resumes from the saved `ptr`.
- `rst` one cycle after issue → no `rsp_valid` for that op; all outputs at reset values the next cycle.
- Inject `add_valid` with an empty tag pipeline → `err`=1 and stays 1 until `rst`. With `ADD_ARB_LOCK_EN`: lock[2] held → requester 2 granted every cycle until `req[2]` drops.
